// File: rtl/serial_rx.sv
// serial_rx: oversampling asynchronous serial receiver.
// Frame = 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
// Each bit is sampled once at its midpoint, measured from the first clock
// edge that sees the line low. A good frame loads data_out one cycle after
// the stop sample. A bad stop bit gives a one-cycle frame_err pulse, and the
// receiver then waits for the line to return high before it accepts a new start.
`timescale 1ns/1ps

module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  // START waits half a bit period, so the later samples land mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;       // clocks within the current bit
  logic [IDX_W-1:0]     idx_r, idx_s;       // data bit index
  logic [DATA_BITS-1:0] shift_r, shift_s;   // data bits as they arrive
  logic                 done_r, done_s;     // good stop seen: load next cycle
  logic                 err_r, err_s;       // bad stop seen: pulse next cycle

  // Register FSM state, counters, shift register and stop-sample strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Next-state logic; rx_in matters only on the start edge and at mid-bit samples.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_in == 1'b0) begin
          state_s = START;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = CNT_ZERO;
          idx_s = IDX_ZERO;
          if (rx_in == 1'b1) begin
            state_s = IDLE;       // false start: line back high at mid-bit
          end else begin
            state_s = DATA;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == FULL_LAST) begin
          cnt_s                = CNT_ZERO;
          shift_s              = shift_r >> 1;
          shift_s[DATA_BITS-1] = rx_in;
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == FULL_LAST) begin
          cnt_s = CNT_ZERO;
          if (rx_in == 1'b1) begin
            done_s  = 1'b1;
            state_s = IDLE;       // allows a back-to-back start on the next edge
          end else begin
            err_s   = 1'b1;
            state_s = WAIT_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_in == 1'b1) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // Output registers: byte hand-off, acknowledge, overrun tracking, status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= {DATA_BITS{1'b0}};
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= err_r;
      busy      <= (state_s != IDLE);
      if (done_r) begin
        // New byte wins over an acknowledge in the same cycle; it is an
        // overrun only if the old byte was still pending and not acknowledged.
        data_out   <= shift_r;
        data_valid <= 1'b1;
        overrun    <= data_valid & ~rd_ack;
      end else if (rd_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized and directed frames for serial_rx. The stimulus
// pushes expected receive events into a queue. A monitor pops an entry
// whenever the DUT presents a byte or a frame error.
`timescale 1ns/1ps

module tb_serial_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  // Cycles from the start edge to the cycle in which the result is visible.
  localparam int LAT = CPB / 2 + (DB + 1) * CPB + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic          rd_ack;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_cyc = -1;
  bit auto_ack = 1'b0;

  typedef struct {
    bit            err;
    logic [DB-1:0] data;
    int            cyc;
  } exp_t;
  exp_t sb_q[$];

  exp_t          mon_e;
  logic          prev_valid = 1'b0;
  logic [DB-1:0] prev_data  = '0;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rd_ack     (rd_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Cycle index: the value after edge n is n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance one clock and set rd_ack for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    rd_ack = (auto_ack && data_valid) || (cyc + 1 == ack_cyc);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) step();
  endtask

  // Send one frame. abort_at > 0 stops after that many clocks, with no expectation.
  task automatic tx_frame(input logic [DB-1:0] d, input bit stop, input bit noisy,
                          input int abort_at, output int t0);
    logic [DB+1:0] bits;
    int n;
    n    = 0;
    bits = {stop, d, 1'b0};
    t0   = cyc + 1;
    if (abort_at == 0)
      sb_q.push_back('{err: (stop == 1'b0), data: d, cyc: t0 + LAT});
    for (int k = 0; k < DB + 2; k++) begin
      int gj;
      gj = -1;
      // Glitches stay clear of the start edge, the mid-bit sample and the stop bit.
      if (noisy && k < DB + 1 && $urandom_range(0, 3) == 0)
        gj = int'($urandom_range(2, 5)) + (($urandom_range(0, 1) == 1) ? 9 : 0);
      for (int j = 0; j < CPB; j++) begin
        rx_in = (j == gj) ? ~bits[k] : bits[k];
        step();
        n++;
        if (abort_at > 0 && n == abort_at) return;
      end
    end
  endtask

  // Monitor: each byte load or frame_err pulse pops one expected event.
  always @(negedge clk) begin
    if (frame_err || (data_valid && (!prev_valid || data_out != prev_data))) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got err=%0d data=%0h cycle=%0d expected none",
                 frame_err, data_out, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (frame_err != mon_e.err || cyc != mon_e.cyc ||
            (!mon_e.err && data_out != mon_e.data)) begin
          errors++;
          $display("FAIL rx_event: got err=%0d data=%0h cycle=%0d expected err=%0d data=%0h cycle=%0d",
                   frame_err, data_out, cyc, mon_e.err, mon_e.data, mon_e.cyc);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      checks++;
      errors++;
      mon_e = sb_q.pop_front();
      $display("FAIL missed_event: got nothing expected err=%0d data=%0h cycle=%0d",
               mon_e.err, mon_e.data, mon_e.cyc);
    end
    prev_valid = data_valid;
    prev_data  = data_out;
  end

  initial begin
    int t;
    int gap;
    logic [DB-1:0] d;
    bit stop;
    reset  = 1'b1;
    rx_in  = 1'b1;
    rd_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_data_out", data_out, 0);
    check("reset_valid", data_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    idle(5);

    // Basic frame, then acknowledge.
    tx_frame(8'hA5, 1'b1, 1'b0, 0, t);
    check("a5_data", data_out, 8'hA5);
    check("a5_valid", data_valid, 1);
    rd_ack = 1'b1;
    step();
    check("a5_ack_clears_valid", data_valid, 0);
    // Acknowledge with nothing pending has no effect.
    rd_ack = 1'b1;
    step();
    check("idle_ack_valid", data_valid, 0);
    check("idle_ack_data", data_out, 8'hA5);
    check("idle_ack_overrun", overrun, 0);

    // Short low glitch: false start.
    t = cyc + 1;
    rx_in = 1'b0;
    repeat (4) step();
    rx_in = 1'b1;
    while (cyc < t + 7) step();
    check("glitch_busy_before_sample", busy, 1);
    step();
    check("glitch_busy_after_sample", busy, 0);
    idle(5);
    tx_frame(8'h3C, 1'b1, 1'b0, 0, t);
    check("3c_data", data_out, 8'h3C);
    rd_ack = 1'b1;
    step();

    // Bad stop bit: frame_err pulse, then wait for the line to return high.
    tx_frame(8'h55, 1'b0, 1'b0, 0, t);
    rx_in = 1'b0;
    repeat (40) step();
    check("ferr_valid_stays_low", data_valid, 0);
    check("ferr_busy_while_low", busy, 1);
    idle(2);
    check("ferr_busy_after_high", busy, 0);
    idle(3);

    // Two back-to-back frames with no acknowledge: overrun.
    tx_frame(8'h11, 1'b1, 1'b0, 0, t);
    tx_frame(8'h22, 1'b1, 1'b0, 0, t);
    check("ovr_data", data_out, 8'h22);
    check("ovr_valid", data_valid, 1);
    check("ovr_flag", overrun, 1);
    rd_ack = 1'b1;
    step();
    check("ovr_ack_valid", data_valid, 0);
    check("ovr_ack_flag", overrun, 0);
    idle(3);

    // Acknowledge in the same cycle as the next byte loads.
    tx_frame(8'h5A, 1'b1, 1'b0, 0, t);
    idle(3);
    ack_cyc = cyc + 1 + LAT;
    tx_frame(8'h7E, 1'b1, 1'b0, 0, t);
    ack_cyc = -1;
    check("same_cycle_ack_data", data_out, 8'h7E);
    check("same_cycle_ack_valid", data_valid, 1);
    check("same_cycle_ack_overrun", overrun, 0);

    // Reset in the middle of a frame.
    tx_frame(8'hFF, 1'b1, 1'b0, 80, t);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("midreset_data_out", data_out, 0);
    check("midreset_valid", data_valid, 0);
    check("midreset_overrun", overrun, 0);
    check("midreset_frame_err", frame_err, 0);
    check("midreset_busy", busy, 0);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    check("post_reset_busy", busy, 0);
    tx_frame(8'h81, 1'b1, 1'b0, 0, t);
    check("post_reset_data", data_out, 8'h81);
    check("post_reset_valid", data_valid, 1);
    rd_ack = 1'b1;
    step();

    // Random frames with glitches between samples and random gaps.
    auto_ack = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      tx_frame(d, stop, 1'b1, 0, t);
      gap = $urandom_range(0, 6);
      if (!stop && gap == 0) gap = 1;
      idle(gap);
    end
    auto_ack = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) idle(1);
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      errors++;
      $display("FAIL drain_timeout: got nothing expected err=%0d data=%0h cycle=%0d",
               mon_e.err, mon_e.data, mon_e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
